a2d_sweep_ctrl: RTL

Sequencer for `SPI_mstr`, which fronts the 8-channel `ADC128S`. It sweeps a set of enabled ADC channels, issues one SPI transaction per channel, and compensates for the ADC's one-transaction response latency. The result of transaction k belongs to the channel requested in transaction k-1. Results are stored in a per-channel result file for downstream logic.

---
 rtl/a2d_sweep_ctrl_pkg.sv | 12 +
 rtl/a2d_sweep_ctrl_chan_sel.sv | 26 ++
 rtl/a2d_sweep_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/a2d_sweep_ctrl_pkg.sv
// rtl/a2d_sweep_ctrl_pkg.sv - shared types and helpers for the ADC sweep sequencer
package a2d_pkg;

  localparam int NUM_CH = 8;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, GAP, FIN} a2d_state_t;

  function automatic logic [15:0] a2d_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_sweep_ctrl_chan_sel.sv
// rtl/a2d_sweep_ctrl_chan_sel.sv - next/lowest enabled channel lookup
module a2d_chan_sel
  import a2d_pkg::*;
(
  input  logic [NUM_CH-1:0] mask,
  input  logic [2:0]        cur,
  output logic [2:0]        nxt,
  output logic              last,
  output logic [2:0]        low
);

  // Walk downward so the final hit is the lowest qualifying channel.
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    low  = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask[i]) low = 3'(i);
      if (mask[i] && (3'(i) > cur)) begin
        nxt  = 3'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/a2d_sweep_ctrl.sv
// rtl/a2d_sweep_ctrl.sv - sweeps enabled ADC channels through SPI_mstr, realigning
// the one-transaction response latency into a per-channel result file.
module a2d_sweep_ctrl
  import a2d_pkg::*;
#(
  parameter int GAP    = 4,
  parameter int PERIOD = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              strt,
  input  logic [NUM_CH-1:0] ch_en,
  output logic              wrt,
  output logic [15:0]       cmd,
  input  logic              done,
  input  logic [15:0]       rd_data,
  input  logic [2:0]        rd_ch,
  output logic [11:0]       rd_val,
  output logic [NUM_CH-1:0] res_vld,
  output logic              busy,
  output logic              cnv_cmplt
);

  a2d_state_t        state;
  logic [NUM_CH-1:0] mask;
  logic [2:0]        cur_ch;
  logic [2:0]        prev_ch;
  logic              have_prev;
  logic              final_txn;
  logic [7:0]        gap_cnt;
  logic [11:0]       result [NUM_CH];

  logic [NUM_CH-1:0] sel_mask;
  logic [2:0]        nxt_ch;
  logic [2:0]        low_ch;
  logic              last_ch;
  logic              due;
  logic              start;
  logic              unused_rd_hi;

  assign unused_rd_hi = ^rd_data[15:12];
  assign start        = (state == IDLE) && (strt || due);
  assign rd_val       = result[rd_ch];

  // In IDLE the live mask is consulted so the first command is ready on the start edge.
  assign sel_mask = (state == IDLE) ? ch_en : mask;

  a2d_chan_sel u_chan_sel (
    .mask (sel_mask),
    .cur  (cur_ch),
    .nxt  (nxt_ch),
    .last (last_ch),
    .low  (low_ch)
  );

  generate
    if (PERIOD > 0) begin : g_period
      localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
      logic [PW-1:0] per_cnt;

      // Saturates once due so a sweep that cannot start yet stays pending.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                          per_cnt <= '0;
        else if (start)                      per_cnt <= '0;
        else if (per_cnt != PW'(PERIOD - 1)) per_cnt <= per_cnt + 1'b1;
      end

      assign due = (per_cnt == PW'(PERIOD - 1));
    end else begin : g_no_period
      assign due = 1'b0;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wrt       <= 1'b0;
      cmd       <= '0;
      busy      <= 1'b0;
      cnv_cmplt <= 1'b0;
      mask      <= '0;
      cur_ch    <= '0;
      prev_ch   <= '0;
      have_prev <= 1'b0;
      final_txn <= 1'b0;
      gap_cnt   <= '0;
      res_vld   <= '0;
      for (int i = 0; i < NUM_CH; i++) result[i] <= '0;
    end else begin
      wrt       <= 1'b0;
      cnv_cmplt <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mask      <= ch_en;
            cur_ch    <= low_ch;
            have_prev <= 1'b0;
            final_txn <= 1'b0;
            busy      <= 1'b1;
            wrt       <= |ch_en;
            if (|ch_en) cmd <= a2d_cmd(low_ch);
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (mask == '0) begin
            busy      <= 1'b0;
            cnv_cmplt <= 1'b1;
            state     <= FIN;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (done) begin
            // The response belongs to the channel requested one transaction earlier.
            if (have_prev) begin
              result[prev_ch]  <= rd_data[11:0];
              res_vld[prev_ch] <= 1'b1;
            end
            have_prev <= 1'b1;
            prev_ch   <= cur_ch;
            cur_ch    <= last_ch ? low_ch : nxt_ch;
            final_txn <= last_ch;
            gap_cnt   <= '0;
            if (final_txn) begin
              busy      <= 1'b0;
              cnv_cmplt <= 1'b1;
              state     <= FIN;
            end else begin
              state <= a2d_pkg::GAP;
            end
          end
        end
        a2d_pkg::GAP: begin
          if (gap_cnt == 8'(GAP - 1)) begin
            wrt   <= 1'b1;
            cmd   <= a2d_cmd(cur_ch);
            state <= ISSUE;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
